mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing one DATA_W-bit output channel among 4 requesters.
//   Selects a requester, drives the 4:1 channel mux select, and holds the grant for a burst.
//   A burst ends on the requester's last beat, at MAX_BURST beats, or when its req drops.
//   Sits between 4 producer blocks and a single downstream consumer with valid/ready.
// PARAMETERS
//   DATA_W     2  width of each requester data bus and of out_data
//   MAX_BURST  4  max beats per grant (>=1); counter width = $clog2(MAX_BURST+1)
// PORTS
//   clk        in   1         single clock, rising edge
//   rst        in   1         asynchronous, active-high reset
//   req        in   4         req[i]=1: requester i has a beat to send
//   last       in   4         last[i]=1: current beat of requester i is its final beat
//   data0..3   in   DATA_W    requester data buses
//   out_ready  in   1         downstream accepts a beat this cycle
//   out_valid  out  1         beat present on out_data
//   out_data   out  DATA_W    granted requester's data (0 when no grant)
//   gnt        out  4         one-hot grant, registered
//   sel        out  2         registered mux select = index of granted requester
//   busy       out  1         1 while in GRANT state
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, gnt=0, sel=0, ptr=3, beat_cnt=0, busy=0;
//     out_valid=0, out_data=0 immediately. Reset mid-burst drops the burst, no beat completes.
//   States: IDLE, GRANT.
//   IDLE: if |req, winner = first i with req[i]=1 scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
//     Next edge: sel<=winner, gnt<=onehot(winner), beat_cnt<=0, state<=GRANT.
//     Latency: req rises at edge t -> gnt valid after edge t+1. No req -> stay IDLE.
//   GRANT: out_valid = req[sel] (combinational); out_data = data[sel] through the
//     4:1 mux keyed by sel; out_data=0 whenever gnt=0.
//     Beat transfer = out_valid & out_ready; on transfer beat_cnt<=beat_cnt+1.
//     Release conditions (evaluated each cycle, any one suffices):
//       a) transfer & last[sel]
//       b) transfer & (beat_cnt+1 == MAX_BURST)
//       c) req[sel]=0 (abort; no transfer that cycle)
//     On release edge: ptr<=sel, gnt<=0, beat_cnt<=0, state<=IDLE.
//   Exactly one bubble cycle (IDLE) between consecutive grants, even if req pending.
//   out_ready=0: no transfer, beat_cnt holds, out_data stays data[sel]; no timeout.
//   Requests from non-granted requesters never affect sel/gnt during GRANT.
//   ptr updates only on release; an aborted grant still counts as served (fairness).
//   gnt and sel change only on clock edges; never more than one gnt bit set.
// TESTING
//   1 Reset: rst=1 mid-cycle -> out_valid=0, gnt=0, sel=0 at once; release, req=4'b1111
//     -> after next edge gnt=4'b0001, sel=0.
//   2 Round robin: req=4'b1111, last=4'b1111, out_ready=1 held -> grant order 0,1,2,3,0;
//     each 1 beat then 1 bubble (gnt=0 one cycle).
//   3 Burst cap: req=4'b0010, last=0, ready=1, data1=2'b10 -> 4 beats out_data=2'b10,
//     sel=1, then gnt=0 one cycle, then gnt=4'b0010 again.
//   4 Backpressure: granted 2, out_ready=0 for 3 cycles -> out_valid=1, out_data=data2
//     stable, beat_cnt unchanged; ready=1 -> beat counted.
//   5 Abort: granted 3 after 1 beat, req[3]->0 -> next edge gnt=0; req=4'b1001 -> gnt=4'b0001.
//   6 Async reset mid-burst (beat_cnt=2): rst pulse between edges -> gnt=0, out_valid=0,
//     ptr=3; after release req=4'b1000 -> gnt=4'b1000.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter that shares one DATA_W-bit output channel among four
//   requesters. A winner is chosen in IDLE, then holds the channel in GRANT
//   for a burst that ends on its last beat, after MAX_BURST beats, or when it
//   drops its request. One IDLE bubble always separates consecutive grants.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous active-high reset
//   req        in   4       req[i]: requester i has a beat to send
//   last       in   4       last[i]: current beat of requester i is its final one
//   data0..3   in   DATA_W  requester data buses
//   out_ready  in   1       downstream accepts a beat this cycle
//   out_valid  out  1       beat present on out_data
//   out_data   out  DATA_W  granted requester's data, 0 when nothing is granted
//   gnt        out  4       one-hot grant (registered)
//   sel        out  2       index of granted requester (registered)
//   busy       out  1       high while in GRANT
module mux_rr_arbiter #(
  parameter int DATA_W    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [3:0]        last,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_sel;
  logic [3:0]        r_gnt;
  logic [CW-1:0]     r_beat_cnt;

  logic [1:0]        w_winner;
  logic [DATA_W-1:0] w_mux;
  logic              w_req_sel;
  logic              w_xfer;
  logic              w_cap;
  logic              w_release;

  // First requester found scanning ptr+1, ptr+2, ptr+3, ptr (mod 4); the
  // last-served requester is therefore checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] rq, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && rq[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign w_winner = rr_pick(req, r_ptr);

  // 4:1 channel mux keyed by the registered select
  always_comb begin
    w_mux = '0;
    case (r_sel)
      2'd0:    w_mux = data0;
      2'd1:    w_mux = data1;
      2'd2:    w_mux = data2;
      2'd3:    w_mux = data3;
      default: w_mux = '0;
    endcase
  end

  assign w_req_sel = req[r_sel];
  assign w_xfer    = (r_state == GRANT) & w_req_sel & out_ready;
  assign w_cap     = ((r_beat_cnt + CW'(1)) == CW'(MAX_BURST));
  // Dropping req releases without a transfer, since out_valid is low then.
  assign w_release = (r_state == GRANT) &
                     (~w_req_sel | (w_xfer & (last[r_sel] | w_cap)));

  // Arbitration FSM: grant selection, burst counting and release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= 4'b0000;
      r_sel      <= 2'd0;
      r_ptr      <= 2'd3;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_sel      <= w_winner;
            r_gnt      <= 4'b0001 << w_winner;
            r_beat_cnt <= '0;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            // An aborted grant still moves the pointer so it counts as served.
            r_ptr      <= r_sel;
            r_gnt      <= 4'b0000;
            r_beat_cnt <= '0;
            r_state    <= IDLE;
          end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 4'b0000;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign busy      = (r_state == GRANT);
  assign out_valid = (r_state == GRANT) & w_req_sel;
  assign out_data  = (|r_gnt) ? w_mux : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] last;
  logic [1:0] data0, data1, data2, data3;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // expected beats as {sel, out_data}
  logic [3:0] exp_q[$];

  mux_rr_arbiter #(.DATA_W(2), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .gnt       (gnt),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // posedge + 2: registered outputs settled, safe point to check and drive
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every completed beat must match the next expected beat
  always @(negedge clk) begin
    logic [3:0] e;
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {28'd0, sel, out_data}, 32'hFF);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {28'd0, sel, out_data}, {28'd0, e});
      end
    end
  end

  initial begin
    logic [3:0] rr_exp [9];
    logic [3:0] cap_exp [6];
    rr_exp  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    cap_exp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010};

    rst = 1'b1; req = 4'b0000; last = 4'b0000; out_ready = 1'b0;
    data0 = 2'b01; data1 = 2'b10; data2 = 2'b11; data3 = 2'b00;

    // 1: reset state
    #2;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_sel", sel, 2'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", out_data, 2'b00);
    step();
    step();

    // 1+2: release reset, all request with single-beat bursts
    rst = 1'b0; req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    exp_q.push_back({2'd0, 2'b01});
    exp_q.push_back({2'd1, 2'b10});
    exp_q.push_back({2'd2, 2'b11});
    exp_q.push_back({2'd3, 2'b00});
    exp_q.push_back({2'd0, 2'b01});
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rr_gnt", gnt, rr_exp[i]);
      chk("rr_busy", busy, 32'(rr_exp[i] != 4'b0000));
      if (i == 0) chk("first_sel", sel, 2'd0);
    end
    step();
    chk("rr_end_gnt", gnt, 4'b0000);
    req = 4'b0000;
    chk("rr_q_empty", exp_q.size(), 0);

    // 3: burst cap on requester 1
    req = 4'b0010; last = 4'b0000; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, 2'b10});
    for (int i = 0; i < 6; i++) begin
      step();
      chk("cap_gnt", gnt, cap_exp[i]);
      if (i < 4) chk("cap_sel", sel, 2'd1);
    end
    req = 4'b0000;
    step();
    chk("cap_abort_gnt", gnt, 4'b0000);
    chk("cap_q_empty", exp_q.size(), 0);

    // 4: backpressure on requester 2; beat count must resume from zero
    req = 4'b0100; last = 4'b0000; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd2, 2'b11});
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_gnt", gnt, 4'b0100);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, 2'b11);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_burst_gnt", gnt, 4'b0100);
    end
    step();
    chk("bp_rel_gnt", gnt, 4'b0000);
    req = 4'b0000;
    chk("bp_q_empty", exp_q.size(), 0);

    // 5: abort of requester 3 after one beat, then pointer favours 0
    req = 4'b1001; last = 4'b0000; out_ready = 1'b1;
    exp_q.push_back({2'd3, 2'b00});
    step();
    chk("ab_gnt", gnt, 4'b1000);
    step();
    chk("ab_gnt_hold", gnt, 4'b1000);
    req = 4'b0001;
    step();
    chk("ab_rel_gnt", gnt, 4'b0000);
    chk("ab_idle_data", out_data, 2'b00);
    chk("ab_idle_valid", out_valid, 1'b0);
    req = 4'b1001;
    step();
    chk("ab_next_gnt", gnt, 4'b0001);
    chk("ab_next_sel", sel, 2'd0);
    req = 4'b0000;
    step();
    chk("ab_end_gnt", gnt, 4'b0000);
    chk("ab_q_empty", exp_q.size(), 0);

    // 6: async reset after two beats of a burst
    req = 4'b0010; last = 4'b0000; out_ready = 1'b1;
    exp_q.push_back({2'd1, 2'b10});
    exp_q.push_back({2'd1, 2'b10});
    step();
    chk("mr_gnt", gnt, 4'b0010);
    step();
    step();
    #1 rst = 1'b1;
    #1;
    chk("mr_rst_gnt", gnt, 4'b0000);
    chk("mr_rst_valid", out_valid, 1'b0);
    chk("mr_rst_sel", sel, 2'd0);
    chk("mr_rst_busy", busy, 1'b0);
    rst = 1'b0;
    // pointer back at 3 means requester 0 wins over 3
    req = 4'b1001;
    step();
    chk("mr_after_gnt", gnt, 4'b0001);
    chk("mr_after_sel", sel, 2'd0);
    req = 4'b0000;
    step();
    step();
    chk("mr_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
